// File: rtl/elevator_controller.sv
// SCAN car scheduler: serves latched floor requests, drives motor/door, and strobes request clears.
// Optional idle return-to-floor-0 behaviour is enabled with ELEVATOR_HOME_RETURN_EN.
module elevator_controller #(
  parameter int BUTTONS_WIDTH    = 8,
  parameter int FLOOR_W          = 3,
  parameter int MOVE_CYCLES      = 16,
  parameter int DOOR_CYCLES      = 32,
  parameter int HOME_IDLE_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
  input  logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
  input  logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
  output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
  output logic [BUTTONS_WIDTH-1:0] inactivate_out_up_levels,
  output logic [BUTTONS_WIDTH-1:0] inactivate_out_down_levels,
  output logic [4:0]               buttons_blocked,
  output logic [FLOOR_W-1:0]       current_floor,
  output logic                     motor_up,
  output logic                     motor_down,
  output logic                     door_open,
  output logic                     dir_up
);

  // state     | meaning
  // IDLE      | car parked, evaluating requests
  // MOVE_UP   | travelling up one floor per MOVE_CYCLES
  // MOVE_DOWN | travelling down one floor per MOVE_CYCLES
  // DOOR      | door open for DOOR_CYCLES, clearing this floor's requests
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0]   MOVE_LD = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DOOR_LD = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP     = FLOOR_W'(BUTTONS_WIDTH - 1);

  state_t                   state_q, state_d;
  logic [FLOOR_W-1:0]       floor_q, floor_d, nf_up, nf_dn;
  logic                     dir_q, dir_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     motor_up_q, motor_up_d, motor_down_q, motor_down_d;
  logic                     door_q, door_d;
  logic [BUTTONS_WIDTH-1:0] inact_q, inact_d, pend;
  logic [4:0]               blocked_q, blocked_d;
  logic                     stop_up, stop_dn, homing;

`ifdef ELEVATOR_HOME_RETURN_EN
  localparam int HOME_W = $clog2(HOME_IDLE_CYCLES);
  localparam logic [HOME_W-1:0] HOME_LAST = HOME_W'(HOME_IDLE_CYCLES - 1);
  logic [HOME_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              homing_q, homing_d;
  assign homing = homing_q;
`else
  assign homing = 1'b0;
`endif

  function automatic logic any_above(input logic [BUTTONS_WIDTH-1:0] p, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++)
      if (i > int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [BUTTONS_WIDTH-1:0] p, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++)
      if (i < int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  // Keep heading while work lies ahead; turn around only if work lies behind.
  function automatic logic door_dir(input logic [BUTTONS_WIDTH-1:0] p, input logic [FLOOR_W-1:0] f,
                                    input logic d);
    logic ahead, behind;
    ahead  = d ? any_above(p, f) : any_below(p, f);
    behind = d ? any_below(p, f) : any_above(p, f);
    return (ahead || !behind) ? d : !d;
  endfunction

  always_comb begin
    pend    = active_in_levels | active_out_up_levels | active_out_down_levels;
    nf_up   = (floor_q == TOP) ? floor_q : floor_q + FLOOR_W'(1);
    nf_dn   = (floor_q == '0) ? floor_q : floor_q - FLOOR_W'(1);
    stop_up = active_in_levels[nf_up] | active_out_up_levels[nf_up] |
              (active_out_down_levels[nf_up] & !any_above(pend, nf_up)) | (nf_up == TOP);
    stop_dn = active_in_levels[nf_dn] | active_out_down_levels[nf_dn] |
              (active_out_up_levels[nf_dn] & !any_below(pend, nf_dn)) | (nf_dn == '0);

    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
`ifdef ELEVATOR_HOME_RETURN_EN
    idle_cnt_d = '0;
    homing_d   = homing_q;
`endif

    case (state_q)
      IDLE: begin
        if (pend[floor_q]) begin
          state_d = DOOR;
          cnt_d   = DOOR_LD;
          dir_d   = door_dir(pend, floor_q, dir_q);
        end else if (any_above(pend, floor_q) && (dir_q || !any_below(pend, floor_q))) begin
          state_d = MOVE_UP;
          cnt_d   = MOVE_LD;
          dir_d   = 1'b1;
        end else if (any_below(pend, floor_q)) begin
          state_d = MOVE_DOWN;
          cnt_d   = MOVE_LD;
          dir_d   = 1'b0;
        end
`ifdef ELEVATOR_HOME_RETURN_EN
        else if (floor_q != '0) begin
          if (idle_cnt_q == HOME_LAST) begin
            state_d  = MOVE_DOWN;
            cnt_d    = MOVE_LD;
            dir_d    = 1'b0;
            homing_d = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + HOME_W'(1);
          end
        end
`endif
      end
      MOVE_UP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          floor_d = nf_up;
          if (pend == '0) begin
            state_d = IDLE;
          end else if (stop_up) begin
            state_d = DOOR;
            cnt_d   = DOOR_LD;
            dir_d   = door_dir(pend, nf_up, dir_q);
          end else begin
            cnt_d = MOVE_LD;
          end
        end
      end
      MOVE_DOWN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          floor_d = nf_dn;
          if (pend == '0) begin
            // A home return keeps going with nothing pending; it parks at floor 0 without a door cycle.
            if (homing && nf_dn != '0) cnt_d = MOVE_LD;
            else state_d = IDLE;
          end else if (stop_dn) begin
            state_d = DOOR;
            cnt_d   = DOOR_LD;
            dir_d   = door_dir(pend, nf_dn, dir_q);
          end else begin
            cnt_d = MOVE_LD;
          end
        end
      end
      DOOR: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef ELEVATOR_HOME_RETURN_EN
    if (state_d != MOVE_DOWN) homing_d = 1'b0;
`endif

    motor_up_d   = (state_d == MOVE_UP);
    motor_down_d = (state_d == MOVE_DOWN);
    door_d       = (state_d == DOOR);
    blocked_d    = door_d ? 5'(floor_d) + 5'd1 : 5'd0;
    inact_d      = door_d ? (BUTTONS_WIDTH'(1) << floor_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      floor_q      <= '0;
      dir_q        <= 1'b1;
      cnt_q        <= '0;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
      door_q       <= 1'b0;
      inact_q      <= '0;
      blocked_q    <= '0;
`ifdef ELEVATOR_HOME_RETURN_EN
      idle_cnt_q   <= '0;
      homing_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      motor_up_q   <= motor_up_d;
      motor_down_q <= motor_down_d;
      door_q       <= door_d;
      inact_q      <= inact_d;
      blocked_q    <= blocked_d;
`ifdef ELEVATOR_HOME_RETURN_EN
      idle_cnt_q   <= idle_cnt_d;
      homing_q     <= homing_d;
`endif
    end
  end

  assign inactivate_in_levels       = inact_q;
  assign inactivate_out_up_levels   = inact_q;
  assign inactivate_out_down_levels = inact_q;
  assign buttons_blocked            = blocked_q;
  assign current_floor              = floor_q;
  assign motor_up                   = motor_up_q;
  assign motor_down                 = motor_down_q;
  assign door_open                  = door_q;
  assign dir_up                     = dir_q;

  a_motor_excl: assert property (@(posedge clk) !(motor_up_q && motor_down_q));
  a_motor_door: assert property (@(posedge clk) !((motor_up_q || motor_down_q) && door_q));

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller; the bench also plays the button block,
// dropping each latched request when its inactivate strobe appears.
module tb_elevator_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_r = '0, up_r = '0, dn_r = '0;
  logic [7:0] inact_in, inact_up, inact_dn;
  logic [4:0] blocked;
  logic [2:0] floor;
  logic       motor_up, motor_down, door_open, dir_up;

  int n_cmp  = 0;
  int n_fail = 0;

  elevator_controller dut (
    .clk                        (clk),
    .reset                      (reset),
    .active_in_levels           (in_r),
    .active_out_up_levels       (up_r),
    .active_out_down_levels     (dn_r),
    .inactivate_in_levels       (inact_in),
    .inactivate_out_up_levels   (inact_up),
    .inactivate_out_down_levels (inact_dn),
    .buttons_blocked            (blocked),
    .current_floor              (floor),
    .motor_up                   (motor_up),
    .motor_down                 (motor_down),
    .door_open                  (door_open),
    .dir_up                     (dir_up)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_r = in_r & ~inact_in;
      up_r = up_r & ~inact_up;
      dn_r = dn_r & ~inact_dn;
      check("interlock_motor_door", 32'((motor_up | motor_down) & door_open), 32'd0);
    end
  endtask

  task automatic wait_door(input logic val, input int max, input string tag);
    int n = 0;
    while (door_open !== val && n < max) begin
      tick(1);
      n++;
    end
    check(tag, 32'(door_open), 32'(val));
  endtask

  task automatic wait_floor(input logic [2:0] f, input int max, input string tag);
    int n = 0;
    while (floor !== f && n < max) begin
      tick(1);
      n++;
    end
    check(tag, 32'(floor), 32'(f));
  endtask

  task automatic do_reset(input logic [7:0] vin, input logic [7:0] vup, input logic [7:0] vdn);
    reset = 1'b0;
    in_r = '0; up_r = '0; dn_r = '0;
    tick(2);
    check("rst_floor", 32'(floor), 32'd0);
    check("rst_dir", 32'(dir_up), 32'd1);
    check("rst_motors", 32'({motor_up, motor_down}), 32'd0);
    check("rst_door", 32'(door_open), 32'd0);
    check("rst_blocked", 32'(blocked), 32'd0);
    check("rst_inact", 32'({inact_in, inact_up, inact_dn}), 32'd0);
    in_r = vin; up_r = vup; dn_r = vdn;
    reset = 1'b1;
  endtask

  initial begin
    // Single car call to floor 3: exact timing of the trip and door.
    do_reset(8'h08, 8'h00, 8'h00);
    check("s1_no_motor_yet", 32'(motor_up), 32'd0);
    tick(1);
    check("s1_motor_up", 32'(motor_up), 32'd1);
    check("s1_floor0", 32'(floor), 32'd0);
    tick(15);
    check("s1_floor0_end", 32'(floor), 32'd0);
    tick(1);
    check("s1_floor1", 32'(floor), 32'd1);
    tick(16);
    check("s1_floor2", 32'(floor), 32'd2);
    tick(15);
    check("s1_floor2_end", 32'(floor), 32'd2);
    check("s1_still_moving", 32'(motor_up), 32'd1);
    tick(1);
    check("s1_floor3", 32'(floor), 32'd3);
    check("s1_door", 32'(door_open), 32'd1);
    check("s1_motor_off", 32'(motor_up), 32'd0);
    check("s1_inact_in", 32'(inact_in), 32'h08);
    check("s1_inact_up", 32'(inact_up), 32'h08);
    check("s1_blocked", 32'(blocked), 32'd4);
    tick(31);
    check("s1_door_last", 32'(door_open), 32'd1);
    check("s1_blocked_last", 32'(blocked), 32'd4);
    tick(1);
    check("s1_door_closed", 32'(door_open), 32'd0);
    check("s1_blocked_clr", 32'(blocked), 32'd0);
    check("s1_inact_clr", 32'(inact_in), 32'h00);
    tick(3);
    check("s1_idle", 32'({motor_up, motor_down, door_open}), 32'd0);

    // SCAN: up to 2 and 5, then reverse to the down call at 1.
    do_reset(8'h24, 8'h00, 8'h02);
    wait_door(1'b1, 100, "s3_door2_timeout");
    check("s3_floor2", 32'(floor), 32'd2);
    check("s3_dir_up2", 32'(dir_up), 32'd1);
    check("s3_inact2", 32'(inact_in), 32'h04);
    wait_door(1'b0, 40, "s3_close2_timeout");
    wait_door(1'b1, 100, "s3_door5_timeout");
    check("s3_floor5", 32'(floor), 32'd5);
    check("s3_dir_down5", 32'(dir_up), 32'd0);
    wait_door(1'b0, 40, "s3_close5_timeout");
    tick(1);
    check("s3_motor_down", 32'(motor_down), 32'd1);
    wait_door(1'b1, 100, "s3_door1_timeout");
    check("s3_floor1", 32'(floor), 32'd1);
    check("s3_dir1", 32'(dir_up), 32'd0);
    check("s3_inact_dn1", 32'(inact_dn), 32'h02);

    // Top floor: saturates at 7, then a hall call at 7 opens the door immediately.
    do_reset(8'h80, 8'h00, 8'h00);
    wait_floor(3'd6, 120, "s4_floor6_timeout");
    in_r[7] = 1'b1;
    wait_door(1'b1, 40, "s4_door7_timeout");
    check("s4_floor7", 32'(floor), 32'd7);
    wait_door(1'b0, 40, "s4_close7_timeout");
    tick(20);
    check("s4_floor_sat", 32'(floor), 32'd7);
    up_r[7] = 1'b1;
    tick(1);
    check("s4_here_door", 32'(door_open), 32'd1);
    check("s4_here_motors", 32'({motor_up, motor_down}), 32'd0);
    check("s4_here_blocked", 32'(blocked), 32'd8);

    // Reset mid-move at floor 4 re-homes to 0, then the call is served again.
    do_reset(8'h80, 8'h00, 8'h00);
    wait_floor(3'd4, 100, "s5_floor4_timeout");
    tick(3);
    reset = 1'b0;
    tick(1);
    check("s5_floor0", 32'(floor), 32'd0);
    check("s5_motors", 32'({motor_up, motor_down}), 32'd0);
    check("s5_dir", 32'(dir_up), 32'd1);
    reset = 1'b1;
    tick(1);
    check("s5_restart", 32'(motor_up), 32'd1);
    wait_door(1'b1, 150, "s5_door7_timeout");
    check("s5_floor7", 32'(floor), 32'd7);

    // Idle at floor 5: home return only with the optional feature.
    do_reset(8'h20, 8'h00, 8'h00);
    wait_door(1'b1, 120, "s6_door5_timeout");
    check("s6_floor5", 32'(floor), 32'd5);
    wait_door(1'b0, 40, "s6_close5_timeout");
    tick(250);
    check("s6_still5", 32'(floor), 32'd5);
    check("s6_no_motor", 32'(motor_down), 32'd0);
`ifdef ELEVATOR_HOME_RETURN_EN
    begin
      int n = 0;
      logic saw_door = 1'b0;
      while (!motor_down && n < 20) begin tick(1); n++; end
      check("s6_home_motor", 32'(motor_down), 32'd1);
      n = 0;
      while (floor != 3'd0 && n < 120) begin
        tick(1);
        n++;
        if (door_open) saw_door = 1'b1;
      end
      check("s6_home_floor0", 32'(floor), 32'd0);
      tick(3);
      check("s6_home_no_door", 32'(saw_door | door_open), 32'd0);
      check("s6_home_idle", 32'(motor_down), 32'd0);
    end
`else
    tick(60);
    check("s6_stays5", 32'(floor), 32'd5);
    check("s6_stays_idle", 32'({motor_up, motor_down, door_open}), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
